// File: rtl/descrambler_rx.sv
// Receive-side lane descrambler: strips the x^23+x^21+x^16+x^8+x^5+x^2+1 keystream
// from the serial lane and packs recovered bits LSB-first into WORD_W-bit words.
module descrambler_rx #(
  parameter int          WORD_W = 32,
  parameter logic [22:0] SEED   = 23'h1DBFBC
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_data_in,
  input  logic              i_enable,
  input  logic              i_scr_rst,
  output logic              o_data_out,
  output logic              o_data_out_vld,
  output logic [WORD_W-1:0] o_word_out,
  output logic              o_word_vld,
  output logic              o_locked
);

  localparam int CNT_W = (WORD_W > 2) ? $clog2(WORD_W) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [22:0]       r_lfsr;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [WORD_W-2:0] r_shift;

  logic w_key;
  logic w_fb;
  logic w_accept;
  logic w_bit;
  logic w_word_done;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_key        = r_lfsr[22];
    w_fb         = r_lfsr[22] ^ r_lfsr[20] ^ r_lfsr[15] ^ r_lfsr[7] ^ r_lfsr[4] ^ r_lfsr[1];
    w_accept     = 1'b0;
    w_bit        = i_data_in ^ r_lfsr[22];
    w_word_done  = (r_bit_cnt == CNT_W'(WORD_W - 1));
    case (r_state)
      IDLE: if (i_scr_rst) w_next_state = RUN;
      RUN: begin
        w_next_state = RUN;
        w_accept     = i_enable && !i_scr_rst;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // RUN is only reachable through scr_rst, so the state bit doubles as the lock flag.
  assign o_locked = (r_state == RUN);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_lfsr         <= SEED;
      r_bit_cnt      <= '0;
      r_shift        <= '0;
      o_data_out     <= 1'b0;
      o_data_out_vld <= 1'b0;
      o_word_out     <= '0;
      o_word_vld     <= 1'b0;
    end else if (i_scr_rst) begin
      r_lfsr         <= SEED;
      r_bit_cnt      <= '0;
      r_shift        <= '0;
      o_data_out_vld <= 1'b0;
      o_word_vld     <= 1'b0;
    end else if (w_accept) begin
      o_data_out     <= w_bit;
      o_data_out_vld <= 1'b1;
      r_lfsr         <= {r_lfsr[21:0], w_fb};
      if (w_word_done) begin
        o_word_out <= {w_bit, r_shift};
        o_word_vld <= 1'b1;
        r_bit_cnt  <= '0;
      end else begin
        o_word_vld <= 1'b0;
        r_bit_cnt  <= r_bit_cnt + 1'b1;
        for (int i = 0; i < WORD_W - 1; i++) begin
          if (r_bit_cnt == CNT_W'(i)) r_shift[i] <= w_bit;
        end
      end
    end else begin
      o_data_out_vld <= 1'b0;
      o_word_vld     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_descrambler_rx.sv
// Scoreboard bench for descrambler_rx: a reference scrambler feeds the lane and
// queues the original bits/words; a monitor pops and compares whenever the DUT emits.
module tb_descrambler_rx;

  localparam int          WORD_W = 32;
  localparam logic [22:0] SEED   = 23'h1DBFBC;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              dataIn = 1'b0;
  logic              enable = 1'b0;
  logic              scrRst = 1'b0;
  logic              dataOut;
  logic              dataOutVld;
  logic [WORD_W-1:0] wordOut;
  logic              wordVld;
  logic              locked;

  int checks = 0;
  int errors = 0;
  int wordsSeen = 0;

  logic              bitQ[$];
  logic [WORD_W-1:0] wordQ[$];

  logic [22:0]       tbLfsr = SEED;
  logic              tbLocked = 1'b0;
  int                wordIdx = 0;
  logic [WORD_W-1:0] tbWord = '0;
  logic [22:0]       seedBits = SEED;

  descrambler_rx #(.WORD_W(WORD_W), .SEED(SEED)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_data_in      (dataIn),
    .i_enable       (enable),
    .i_scr_rst      (scrRst),
    .o_data_out     (dataOut),
    .o_data_out_vld (dataOutVld),
    .o_word_out     (wordOut),
    .o_word_vld     (wordVld),
    .o_locked       (locked)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drives one cycle at the falling edge. Accepted bits are scrambled with the
  // reference LFSR (unless rawMode, where data_in is taken as-is and the caller
  // queues the expected descrambled bit itself).
  task automatic applyStimulus(input logic en, input logic bitIn, input logic scr, input logic rawMode);
    logic key;
    logic fb;
    logic din;
    logic outBit;
    @(negedge clk);
    key = tbLfsr[22];
    din = (rawMode || !(tbLocked && en && !scr)) ? bitIn : (bitIn ^ key);
    enable = en;
    dataIn = din;
    scrRst = scr;
    if (scr) begin
      tbLfsr   = SEED;
      tbLocked = 1'b1;
      wordIdx  = 0;
      tbWord   = '0;
    end else if (tbLocked && en) begin
      outBit = din ^ key;
      if (!rawMode) bitQ.push_back(outBit);
      fb = tbLfsr[22] ^ tbLfsr[20] ^ tbLfsr[15] ^ tbLfsr[7] ^ tbLfsr[4] ^ tbLfsr[1];
      tbLfsr = {tbLfsr[21:0], fb};
      tbWord[wordIdx] = outBit;
      if (wordIdx == WORD_W - 1) begin
        wordQ.push_back(tbWord);
        wordIdx = 0;
      end else begin
        wordIdx++;
      end
    end
  endtask

  // scr_rst followed by 23 zero bits: the output must be the seed itself, MSB first.
  task automatic runSeedSequence();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 23; i++) begin
      bitQ.push_back(seedBits[22-i]);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
      checkOutput("locked_after_scr_rst", 32'(locked), 32'd1);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (dataOutVld) begin
        if (bitQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_data_out_vld: got 1, expected 0");
        end else begin
          checkOutput("data_out", 32'(dataOut), 32'(bitQ.pop_front()));
        end
      end
      if (wordVld) begin
        wordsSeen++;
        if (wordQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_word_vld: got 1, expected 0 (word 0x%0h)", wordOut);
        end else begin
          checkOutput("word_out", wordOut, wordQ.pop_front());
        end
      end
    end
  end

  initial begin
    int startWords;
    int accepted;
    logic en;

    repeat (2) @(negedge clk);
    checkOutput("reset_data_out", 32'(dataOut), 32'd0);
    checkOutput("reset_data_out_vld", 32'(dataOutVld), 32'd0);
    checkOutput("reset_word_out", wordOut, 32'd0);
    checkOutput("reset_word_vld", 32'(wordVld), 32'd0);
    checkOutput("reset_locked", 32'(locked), 32'd0);
    rst = 1'b0;

    $display("[TB] idle: enable without scr_rst");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput("idle_data_out_vld", 32'(dataOutVld), 32'd0);
      checkOutput("idle_word_vld", 32'(wordVld), 32'd0);
      checkOutput("idle_locked", 32'(locked), 32'd0);
    end

    $display("[TB] seed sequence");
    runSeedSequence();

    $display("[TB] continuous 4096-bit stream");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    startWords = wordsSeen;
    for (int i = 0; i < 4096; i++) applyStimulus(1'b1, 1'($urandom), 1'b0, 1'b0);
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("stream_word_count", 32'(wordsSeen - startWords), 32'd128);

    $display("[TB] gapped 4096-bit stream");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    startWords = wordsSeen;
    accepted = 0;
    while (accepted < 4096) begin
      en = ($urandom_range(0, 99) < 40);
      applyStimulus(en, 1'($urandom), 1'b0, 1'b0);
      if (en) accepted++;
    end
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("gapped_word_count", 32'(wordsSeen - startWords), 32'd128);

    $display("[TB] scr_rst at bit 17");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    startWords = wordsSeen;
    for (int i = 0; i < 17; i++) applyStimulus(1'b1, 1'($urandom), 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < WORD_W; i++) applyStimulus(1'b1, 1'($urandom), 1'b0, 1'b0);
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("resync_word_count", 32'(wordsSeen - startWords), 32'd1);

    $display("[TB] async reset mid-word");
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'($urandom), 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    checkOutput("pending_bits_before_rst", 32'(bitQ.size()), 32'd0);
    rst = 1'b1;
    #1;
    checkOutput("rst_data_out", 32'(dataOut), 32'd0);
    checkOutput("rst_data_out_vld", 32'(dataOutVld), 32'd0);
    checkOutput("rst_word_out", wordOut, 32'd0);
    checkOutput("rst_word_vld", 32'(wordVld), 32'd0);
    checkOutput("rst_locked", 32'(locked), 32'd0);
    #1;
    rst = 1'b0;
    tbLocked = 1'b0;
    tbLfsr   = SEED;
    wordIdx  = 0;
    tbWord   = '0;
    runSeedSequence();

    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("pending_bits", 32'(bitQ.size()), 32'd0);
    checkOutput("pending_words", 32'(wordQ.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
